// File: rtl/mem_responder.sv
// mem_responder: main-memory backing store for the cache miss engines.
// Writes commit at the presenting edge. Reads are sampled at their issue
// edge and returned through a LATENCY-deep valid/data pipeline, one per cycle.
module mem_responder #(
   parameter int ADDR_WIDTH = 16,
   parameter int LATENCY    = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  wr,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [15:0]           data_in,
   output logic [15:0]           data_out,
   output logic                  data_valid,
   output logic [2:0]            outstanding
);

   localparam int DEPTH = 1 << (ADDR_WIDTH - 1);

   logic [15:0]           r_mem [DEPTH];
   logic [15:0]           r_data [LATENCY];
   logic                  r_vld [LATENCY];
   logic [2:0]            r_outstanding;

   logic [ADDR_WIDTH-2:0] w_idx;
   logic                  w_rd_issue;
   logic                  w_wr_commit;
   logic                  w_retire;
   logic                  w_unused_addr_lsb;

   // Byte address to word index; the byte-select bit has no meaning here.
   assign w_idx             = addr[ADDR_WIDTH-1:1];
   assign w_unused_addr_lsb = addr[0];

   // Requests seen while reset is high are dropped, writes included.
   assign w_rd_issue  = enable & ~wr & ~rst;
   assign w_wr_commit = enable & wr & ~rst;

   // The last stage holding a valid read is the data_valid cycle.
   assign w_retire = r_vld[LATENCY-1];

   // Array port: commit writes and register the addressed word every cycle.
   // Reads and writes are exclusive per request, so read-first ordering is
   // never observable through the pipeline.
   always_ff @(posedge clk) begin
      if (w_wr_commit) begin
         r_mem[w_idx] <= data_in;
      end
      r_data[0] <= r_mem[w_idx];
   end

   // Stage 1 valid: marks the registered word as a real read.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld[0] <= 1'b0;
      end else begin
         r_vld[0] <= w_rd_issue;
      end
   end

   genvar gi;
   generate
      for (gi = 1; gi < LATENCY; gi++) begin : g_stage
         // Advance valid and data one stage; only valid bits need clearing.
         always_ff @(posedge clk) begin
            if (rst) begin
               r_vld[gi] <= 1'b0;
            end else begin
               r_vld[gi] <= r_vld[gi-1];
            end
            r_data[gi] <= r_data[gi-1];
         end
      end
   endgenerate

   // Count reads in flight: up on issue, down on retire, hold when both.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_outstanding <= 3'd0;
      end else begin
         case ({w_rd_issue, w_retire})
            2'b10:   r_outstanding <= r_outstanding + 3'd1;
            2'b01:   r_outstanding <= r_outstanding - 3'd1;
            default: r_outstanding <= r_outstanding;
         endcase
      end
   end

   // Outputs come straight from registers; data is forced to zero when idle.
   assign data_valid  = w_retire;
   assign data_out    = w_retire ? r_data[LATENCY-1] : 16'h0000;
   assign outstanding = r_outstanding;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench for mem_responder. Expected read data
// and due cycle are queued at issue; the negedge monitor pops and compares.
module tb_mem_responder;

   localparam int AW  = 16;
   localparam int LAT = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          enable = 1'b0;
   logic          wr = 1'b0;
   logic [AW-1:0] addr = '0;
   logic [15:0]   data_in = '0;
   logic [15:0]   data_out;
   logic          data_valid;
   logic [2:0]    outstanding;

   typedef struct {
      int          due;
      logic [15:0] data;
   } exp_t;

   exp_t        sb_q[$];
   int          iss_q[$];
   logic [15:0] model_mem [int];
   int          cyc = 0;
   int          n_checks = 0;
   int          n_errors = 0;
   bit          mon_en = 1'b0;
   int          peak_out = 0;

   mem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .wr          (wr),
      .addr        (addr),
      .data_in     (data_in),
      .data_out    (data_out),
      .data_valid  (data_valid),
      .outstanding (outstanding)
   );

   always #5 clk = ~clk;

   // Edge counter used to time-stamp issues and completions.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Present one request for one edge and update the model at that edge.
   task automatic drive(input logic en, input logic w, input logic [15:0] a,
                        input logic [15:0] d, input logic r);
      int issue_at;
      enable  = en;
      wr      = w;
      addr    = a;
      data_in = d;
      rst     = r;
      issue_at = cyc + 1;
      @(posedge clk);
      if (r) begin
         sb_q.delete();
         iss_q.delete();
      end else if (en && w) begin
         model_mem[int'(a[15:1])] = d;
         $display("write addr=%04h data=%04h", a, d);
      end else if (en) begin
         sb_q.push_back('{due: issue_at + LAT - 1, data: model_mem[int'(a[15:1])]});
         iss_q.push_back(issue_at);
         $display("read  addr=%04h expect=%04h", a, model_mem[int'(a[15:1])]);
      end
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
   endtask

   // Monitor: compare outstanding and any completing read every cycle.
   always @(negedge clk) begin
      if (mon_en) begin
         int exp_out;
         exp_out = 0;
         foreach (iss_q[i]) if (iss_q[i] <= cyc && cyc < iss_q[i] + LAT) exp_out++;
         check("outstanding", outstanding, exp_out);
         if (int'(outstanding) > peak_out) peak_out = int'(outstanding);
         while (iss_q.size() > 0 && cyc >= iss_q[0] + LAT) void'(iss_q.pop_front());
         if (data_valid) begin
            if (sb_q.size() == 0) begin
               check("spurious_valid", 1, 0);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               check("latency", cyc, e.due);
               check("rdata", data_out, e.data);
               $display("resp  data=%04h expect=%04h cycle=%0d", data_out, e.data, cyc);
            end
         end else begin
            check("idle_data", data_out, 0);
            if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
               check("missing_valid", 0, 1);
               void'(sb_q.pop_front());
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset
      drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
      drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
      mon_en = 1'b1;
      #0;
      check("rst_valid", data_valid, 0);
      check("rst_outstanding", outstanding, 0);
      check("rst_data", data_out, 0);

      // Single write/read
      drive(1'b1, 1'b1, 16'h0010, 16'hBEEF, 1'b0);
      drive(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);
      idle(LAT + 2);

      // Streaming reads
      drive(1'b1, 1'b1, 16'h0000, 16'h1111, 1'b0);
      drive(1'b1, 1'b1, 16'h0002, 16'h2222, 1'b0);
      drive(1'b1, 1'b1, 16'h0004, 16'h3333, 1'b0);
      drive(1'b1, 1'b1, 16'h0006, 16'h4444, 1'b0);
      peak_out = 0;
      drive(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0);
      drive(1'b1, 1'b0, 16'h0002, 16'h0000, 1'b0);
      drive(1'b1, 1'b0, 16'h0004, 16'h0000, 1'b0);
      drive(1'b1, 1'b0, 16'h0006, 16'h0000, 1'b0);
      idle(LAT + 2);
      check("stream_peak", peak_out, LAT);

      // Write under an in-flight read
      drive(1'b1, 1'b1, 16'h0020, 16'hAAAA, 1'b0);
      drive(1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0);
      drive(1'b1, 1'b1, 16'h0020, 16'h5555, 1'b0);
      drive(1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0);
      idle(LAT + 2);

      // addr[0] ignored
      drive(1'b1, 1'b1, 16'h0031, 16'h1234, 1'b0);
      drive(1'b1, 1'b0, 16'h0030, 16'h0000, 1'b0);
      idle(LAT + 2);

      // Reset mid-flight: third read coincides with reset and is dropped
      drive(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0);
      drive(1'b1, 1'b0, 16'h0002, 16'h0000, 1'b0);
      drive(1'b1, 1'b0, 16'h0004, 16'h0000, 1'b1);
      #0;
      check("midrst_outstanding", outstanding, 0);
      idle(LAT + 2);
      drive(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);
      idle(LAT + 2);

      // Idle with wr set must not write or produce responses
      drive(1'b1, 1'b1, 16'h0040, 16'h7777, 1'b0);
      for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 16'h0040, 16'hFFFF, 1'b0);
      drive(1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0);
      idle(LAT + 2);

      // Write attempted during reset must be ignored
      drive(1'b1, 1'b1, 16'h0040, 16'hDEAD, 1'b1);
      drive(1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0);
      idle(LAT + 2);

      check("drain", sb_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
# mem_responder

Multicycle main-memory responder serving the cache-to-memory request interface: the `icache`/`dcache` miss engines and their arbiter issue `enable`/`wr`/`addr`/`data_in`, and this block returns read data with `data_valid` after a fixed latency. Reads are fully pipelined, one new read per cycle. Writes commit in the cycle they are presented. It sits below the cache arbiter as the single backing store for both caches.

## Interface
Parameters:
- `ADDR_WIDTH`, default 16: byte-address width. Storage is 2^(ADDR_WIDTH-1) 16-bit words.
- `LATENCY`, default 4: read latency in cycles, range 1–7.

Ports:
- `clk`  input  1: single clock. Everything is sampled on the rising edge.
- `rst`  input  1: synchronous, active-high reset.
- `enable`  input  1: request valid this cycle.
- `wr`  input  1: qualified by `enable`. 1 = write, 0 = read.
- `addr`  input  ADDR_WIDTH: byte address. Word index is `addr[ADDR_WIDTH-1:1]`; `addr[0]` is ignored.
- `data_in`  input  16: write data.
- `data_out`  output  16: read data, meaningful only while `data_valid`=1, otherwise 16'h0000.
- `data_valid`  output  1: one-cycle pulse per completed read.
- `outstanding`  output  3: number of reads currently in flight, 0..LATENCY.

## Operation
- **Write** (`enable`=1, `wr`=1): writes `mem[addr[ADDR_WIDTH-1:1]] <= data_in` at the rising edge. It produces no `data_valid` pulse and has no effect on reads already in flight.
- **Read** (`enable`=1, `wr`=0): samples the array at the issue edge (issue cycle N) and loads that word into stage 1 of a LATENCY-deep valid/data shift pipeline.
  - In cycle N+LATENCY, `data_valid`=1 and `data_out`=word.
- **Ordering.** Reads complete in issue order, one per cycle at most.
  - A read issued after a write to the same word returns the new value.
  - A read issued before the write returns the old value, even if it is still in flight when the write commits.
- **Idle** (`enable`=0): `wr`, `addr` and `data_in` are don't-care. The pipeline still advances.
- **`outstanding`**: an up/down counter.
  - +1 on a read issue.
  - −1 when the pipeline's last stage holds a valid read (the `data_valid` cycle).
  - Both events in the same cycle leave it unchanged.
  - With back-to-back reads it saturates naturally at LATENCY and never wraps.
- **No backpressure.** The requester must accept data in the `data_valid` cycle; a missed pulse is not replayed.
- **Reset.**
  - At the reset edge the pipeline valid bits clear, `data_out`=16'h0000, `data_valid`=0, `outstanding`=0.
  - Reads in flight are discarded and never return.
  - Array contents are unaffected by reset and are undefined until written.
  - Requests presented while `rst`=1 are ignored, including writes.

## Timing
- Read latency is exactly LATENCY cycles from the issue edge to the `data_valid` cycle. Throughput is 1 read per cycle.
- Write latency is 0 cycles: the written value is visible to a read issued on the next edge.
- `data_out`, `data_valid` and `outstanding` are registered. There is no combinational input-to-output path.
- A read presented in the same cycle a reset is asserted is dropped.
- The first request is accepted on the first edge with `rst`=0.
- Reset values: `data_out`=16'h0000, `data_valid`=0, `outstanding`=3'd0.

## Test plan
- **Single write/read.** After reset, write 16'hBEEF to 16'h0010, then read 16'h0010 one cycle later.
  - `data_valid` is high only 4 cycles after the read issue, with `data_out`=16'hBEEF.
  - `outstanding` goes 1,1,1,1,0.
- **Streaming reads.** Write 16'h1111/2222/3333/4444 to 16'h0000/2/4/6, then issue 4 back-to-back reads.
  - 4 consecutive `data_valid` cycles carry the values in order.
  - `outstanding` peaks at 4.
- **Write under an in-flight read.** Write 16'hAAAA to 16'h0020 and read it. In the next cycle, write 16'h5555 to 16'h0020, then read it again.
  - The first read returns 16'hAAAA, the second 16'h5555.
- **`addr[0]` ignored.** Write 16'h1234 to 16'h0031, read 16'h0030 → 16'h1234.
- **Reset mid-flight.** Issue 3 reads, assert `rst` 2 cycles after the first issue, deassert next cycle.
  - No `data_valid` ever appears for those reads.
  - `outstanding`=0 after the reset edge.
  - A subsequent read of a previously written word returns correctly with 4-cycle latency.
- **Idle with `wr` set.** `enable`=0, `wr`=1, `data_in`=16'hFFFF to 16'h0040 for several cycles.
  - A later read of 16'h0040 returns the prior value.
  - No `data_valid` pulses occur during the idle cycles.
